// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit seven-segment display.
//
// Each digit owns a slot of DIGIT_CYCLES clocks. The first BLANK_CYCLES clocks of a slot
// keep every anode off so the previous digit's pattern cannot ghost into the next one.
// The pattern and enable for the slot's digit are captured once, on the edge that ends
// the last blank cycle, and held until the slot ends, so input writes never tear a lit digit.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   seg_in_0..7    logical segment pattern per digit (1 = lit; bit7 = dp, bits6..0 = g..a)
//   digit_en       per-digit enable; a cleared bit keeps that digit dark during its slot
//   seg_out        physical segment lines (polarity from SEG_ACTIVE_LOW)
//   an_out         physical digit selects, one-hot when lit (polarity from AN_ACTIVE_LOW)
//   scan_idx       index of the digit owning the current slot
//   frame_tick     one-cycle pulse on the first cycle of each new 8-digit frame
module seg7_scan_driver #(
  parameter int unsigned DIGIT_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seg_in_0,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  input  logic [7:0] seg_in_5,
  input  logic [7:0] seg_in_6,
  input  logic [7:0] seg_in_7,
  input  logic [7:0] digit_en,
  output logic [7:0] seg_out,
  output logic [7:0] an_out,
  output logic [2:0] scan_idx,
  output logic       frame_tick
);

  localparam logic [7:0]  SegOff   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  AnOff    = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [15:0] LastCnt  = 16'(DIGIT_CYCLES - 1);
  localparam logic [15:0] LatchCnt = 16'(BLANK_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  scan_idx_q, scan_idx_d;
  logic [7:0]  seg_out_q, seg_out_d;
  logic [7:0]  an_out_q, an_out_d;
  logic        frame_tick_q, frame_tick_d;

  logic [7:0]  seg_sel;
  logic [7:0]  an_onehot;
  logic        slot_end;
  logic        latch_edge;

  // Pattern of the digit that owns the current slot.
  always_comb begin
    seg_sel = seg_in_0;
    case (scan_idx_q)
      3'd0:    seg_sel = seg_in_0;
      3'd1:    seg_sel = seg_in_1;
      3'd2:    seg_sel = seg_in_2;
      3'd3:    seg_sel = seg_in_3;
      3'd4:    seg_sel = seg_in_4;
      3'd5:    seg_sel = seg_in_5;
      3'd6:    seg_sel = seg_in_6;
      default: seg_sel = seg_in_7;
    endcase
  end

  always_comb begin
    an_onehot    = 8'h01 << scan_idx_q;
    slot_end     = (cnt_q == LastCnt);
    latch_edge   = (cnt_q == LatchCnt);

    cnt_d        = cnt_q + 16'd1;
    scan_idx_d   = scan_idx_q;
    seg_out_d    = seg_out_q;
    an_out_d     = an_out_q;
    frame_tick_d = 1'b0;

    if (slot_end) begin
      cnt_d        = '0;
      scan_idx_d   = scan_idx_q + 3'd1;
      seg_out_d    = SegOff;
      an_out_d     = AnOff;
      // Marks the first blank cycle of slot 0.
      frame_tick_d = (scan_idx_q == 3'd7);
    end else if (latch_edge) begin
      if (digit_en[scan_idx_q]) begin
        seg_out_d = SEG_ACTIVE_LOW ? ~seg_sel : seg_sel;
        an_out_d  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end else begin
        // Disabled digits still consume their slot to keep the refresh rate constant.
        seg_out_d = SegOff;
        an_out_d  = AnOff;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      scan_idx_q   <= '0;
      seg_out_q    <= SegOff;
      an_out_q     <= AnOff;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      scan_idx_q   <= scan_idx_d;
      seg_out_q    <= seg_out_d;
      an_out_q     <= an_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign an_out     = an_out_q;
  assign scan_idx   = scan_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. Three instances share clock, reset and inputs:
//   A: DIGIT_CYCLES=8, BLANK_CYCLES=2, active-low segments and anodes
//   B: DIGIT_CYCLES=8, BLANK_CYCLES=2, active-high segments and anodes
//   C: DIGIT_CYCLES=2, BLANK_CYCLES=1, active-low (minimum blank)
// The reference model derives slot, digit and phase from the cycle number since reset
// with plain division/modulo and remembers what each digit showed at its capture point.
module tb_seg7_scan_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] seg_in [8];
  logic [7:0] digit_en;

  logic [7:0] seg_a, an_a, seg_b, an_b, seg_c, an_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       tick_a, tick_b, tick_c;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned t;
  logic [7:0]  snap_seg [3];
  logic        snap_en  [3];
  logic        prev_c_act;

  seg7_scan_driver #(
    .DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clock(clock), .reset(reset),
    .seg_in_0(seg_in[0]), .seg_in_1(seg_in[1]), .seg_in_2(seg_in[2]), .seg_in_3(seg_in[3]),
    .seg_in_4(seg_in[4]), .seg_in_5(seg_in[5]), .seg_in_6(seg_in[6]), .seg_in_7(seg_in[7]),
    .digit_en(digit_en), .seg_out(seg_a), .an_out(an_a), .scan_idx(idx_a),
    .frame_tick(tick_a)
  );

  seg7_scan_driver #(
    .DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .clock(clock), .reset(reset),
    .seg_in_0(seg_in[0]), .seg_in_1(seg_in[1]), .seg_in_2(seg_in[2]), .seg_in_3(seg_in[3]),
    .seg_in_4(seg_in[4]), .seg_in_5(seg_in[5]), .seg_in_6(seg_in[6]), .seg_in_7(seg_in[7]),
    .digit_en(digit_en), .seg_out(seg_b), .an_out(an_b), .scan_idx(idx_b),
    .frame_tick(tick_b)
  );

  seg7_scan_driver #(
    .DIGIT_CYCLES(2), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_c (
    .clock(clock), .reset(reset),
    .seg_in_0(seg_in[0]), .seg_in_1(seg_in[1]), .seg_in_2(seg_in[2]), .seg_in_3(seg_in[3]),
    .seg_in_4(seg_in[4]), .seg_in_5(seg_in[5]), .seg_in_6(seg_in[6]), .seg_in_7(seg_in[7]),
    .digit_en(digit_en), .seg_out(seg_c), .an_out(an_c), .scan_idx(idx_c),
    .frame_tick(tick_c)
  );

  function automatic int unsigned dut_d(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic int unsigned dut_b(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare one instance against the model for cycle t.
  task automatic check_dut(input int k, input logic [7:0] seg_o, input logic [7:0] an_o,
                           input logic [2:0] idx_o, input logic tick_o);
    int unsigned d, b, c, idx;
    bit          low;
    logic [7:0]  off, one, oh, es, ea;
    logic        et;
    d   = dut_d(k);
    b   = dut_b(k);
    low = (k != 1);
    c   = t % d;
    idx = (t / d) % 8;
    off = low ? 8'hFF : 8'h00;
    one = 8'h01;
    oh  = one << idx;
    if (c < b || !snap_en[k]) begin
      es = off;
      ea = off;
    end else begin
      es = low ? ~snap_seg[k] : snap_seg[k];
      ea = low ? ~oh : oh;
    end
    et = (t > 0) && (t % (8 * d) == 0);
    check($sformatf("dut%0d seg t=%0d", k, t), seg_o, es);
    check($sformatf("dut%0d an t=%0d", k, t), an_o, ea);
    check($sformatf("dut%0d idx t=%0d", k, t), {5'b0, idx_o}, 8'(idx));
    check($sformatf("dut%0d tick t=%0d", k, t), {7'b0, tick_o}, {7'b0, et});
  endtask

  // Check this cycle, record what each digit shows at its capture edge, then advance.
  task automatic step();
    int unsigned d, slot;
    logic        act;
    check_dut(0, seg_a, an_a, idx_a, tick_a);
    check_dut(1, seg_b, an_b, idx_b, tick_b);
    check_dut(2, seg_c, an_c, idx_c, tick_c);
    act = (an_c != 8'hFF);
    check($sformatf("dutC adjacent lit t=%0d", t), {7'b0, prev_c_act && act}, 8'h00);
    prev_c_act = act;
    for (int k = 0; k < 3; k++) begin
      d    = dut_d(k);
      slot = (t / d) % 8;
      if (t % d == dut_b(k) - 1) begin
        snap_seg[k] = seg_in[slot];
        snap_en[k]  = digit_en[slot];
      end
    end
    @(posedge clock);
    @(negedge clock);
    t++;
  endtask

  task automatic load_walking();
    logic [7:0] one;
    one = 8'h01;
    for (int i = 0; i < 8; i++) seg_in[i] = one << i;
  endtask

  initial begin
    reset      = 1'b1;
    digit_en   = 8'hFF;
    t          = 0;
    prev_c_act = 1'b0;
    load_walking();
    for (int k = 0; k < 3; k++) begin
      snap_seg[k] = 8'h00;
      snap_en[k]  = 1'b0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset A seg", seg_a, 8'hFF);
    check("reset A an", an_a, 8'hFF);
    check("reset A idx", {5'b0, idx_a}, 8'h00);
    check("reset A tick", {7'b0, tick_a}, 8'h00);
    check("reset B seg", seg_b, 8'h00);
    check("reset B an", an_b, 8'h00);
    reset = 1'b0;

    // Basic scan, disable mask, mid-slot write, then random traffic.
    while (t < 428) begin
      if (t == 64) begin
        digit_en  = 8'hA5;
        seg_in[2] = 8'h3F;
      end
      if (t == 84) seg_in[2] = 8'h06;
      if (t == 128 || t == 384) digit_en = 8'hFF;
      if (t >= 192 && t < 384) begin
        if ($urandom_range(3) == 0) seg_in[$urandom_range(7)] = 8'($urandom);
        if ($urandom_range(7) == 0) digit_en = 8'($urandom);
      end
      if (t == 1)   check("slot0 blank an", an_a, 8'hFF);
      if (t == 2)   check("slot0 lit an", an_a, 8'hFE);
      if (t == 2)   check("slot0 lit seg", seg_a, 8'hFE);
      if (t == 26)  check("slot3 lit an", an_a, 8'hF7);
      if (t == 26)  check("slot3 lit seg", seg_a, 8'hF7);
      if (t == 63)  check("tick before frame", {7'b0, tick_a}, 8'h00);
      if (t == 64)  check("tick at frame", {7'b0, tick_a}, 8'h01);
      if (t == 16)  check("minblank tick", {7'b0, tick_c}, 8'h01);
      if (t == 76)  check("masked slot1 an", an_a, 8'hFF);
      if (t == 76)  check("masked slot1 seg", seg_a, 8'hFF);
      if (t == 106) check("mask slot5 an", an_a, 8'hDF);
      if (t == 86)  check("midwrite held seg", seg_a, 8'hC0);
      if (t == 146) check("midwrite next frame seg", seg_a, 8'hF9);
      step();
    end

    // Slot 5 cycle 4: lit, then reset between edges.
    check("pre-reset slot5 an", an_a, 8'hDF);
    reset = 1'b1;
    #1;
    check("async reset A an", an_a, 8'hFF);
    check("async reset A seg", seg_a, 8'hFF);
    check("async reset A idx", {5'b0, idx_a}, 8'h00);
    check("async reset A tick", {7'b0, tick_a}, 8'h00);
    check("async reset B an", an_b, 8'h00);
    @(posedge clock);
    @(negedge clock);
    check("held reset A an", an_a, 8'hFF);
    load_walking();
    digit_en   = 8'hFF;
    reset      = 1'b0;
    t          = 0;
    prev_c_act = 1'b0;

    // Restart, then polarity check on instance B.
    while (t < 80) begin
      if (t == 8) begin
        seg_in[1] = 8'h5B;
        digit_en  = 8'h02;
      end
      if (t == 2)  check("restart slot0 an", an_a, 8'hFE);
      if (t == 0)  check("B idle an", an_b, 8'h00);
      if (t == 0)  check("B idle seg", seg_b, 8'h00);
      if (t == 12) check("B slot1 an", an_b, 8'h02);
      if (t == 12) check("B slot1 seg", seg_b, 8'h5B);
      if (t == 20) check("B slot2 dark an", an_b, 8'h00);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
